dram_arbiter: RTL
=================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter RAM_WORDS, default 120072, number of 32-bit words behind the RAM port; word index = addr[31:2].
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 c_req  input  1  core request; held high until c_ack.
REQ-005 c_we  input  1  core write (1) / read (0).
REQ-006 c_size  input  2  00 byte, 01 halfword, 10 word; 11 illegal.
REQ-007 c_unsigned  input  1  zero-extend (1) / sign-extend (0) sub-word loads.
REQ-008 c_addr  input  32  core byte address.
REQ-009 c_wdata  input  32  store data, right-aligned.
REQ-010 c_rdata  output  32  load data, extended, valid while c_ack=1.
REQ-011 c_ack  output  1  one-cycle completion pulse.
REQ-012 c_err  output  1  misaligned or illegal-size request, pulses with c_ack.
REQ-013 l_req, l_we, l_addr[31:0], l_wdata[31:0]  input  loader port, word-only, held until l_ack.
REQ-014 l_rdata  output  32  loader read data, valid while l_ack=1.
REQ-015 l_ack  output  1  one-cycle completion pulse.
REQ-016 ram_we  output  1, ram_addr  output  32, ram_wdata  output  32  to RAM; RAM writes on posedge when ram_we=1.
REQ-017 ram_rdata  input  32  combinational RAM read of ram_addr.

Function
REQ-018 FSM states IDLE, ACCESS, MERGE_WR; reset state IDLE.
REQ-019 IDLE: if any eligible request, latch winner's fields and grant; go to ACCESS; else stay.
REQ-020 A port is ineligible in IDLE during the cycle its own ack is high.
REQ-021 Both eligible: grant port not granted last (round-robin bit); reset value of bit makes core win first.
REQ-022 Loader requests: word access; l_addr[1:0] ignored.
REQ-023 Core error: c_size=11, halfword with addr[0]=1, or word with addr[1:0]!=0; ACCESS issues no write, next cycle c_ack=c_err=1, c_rdata=0.
REQ-024 ACCESS: ram_addr = latched addr with [1:0] forced 00; read or word write completes here (ram_we=1 for word write, ram_wdata = wdata); ack next cycle, FSM to IDLE.
REQ-025 Read: ram_rdata captured at end of ACCESS; core selects byte/half by addr[1:0]/addr[1], extends per c_unsigned.
REQ-026 Sub-word core store: ACCESS reads word (ram_we=0), registers merge of wdata lane into it; MERGE_WR drives ram_we=1 with merged word; ack next cycle, FSM to IDLE.
REQ-027 Latency from req sampled in IDLE at edge N: ack high in cycle N+2 (read, word write, error), N+3 (sub-word store).
REQ-028 ack, err are registered, high exactly one cycle; at most one of c_ack/l_ack high per cycle.
REQ-029 ram_we high only in ACCESS (word write) or MERGE_WR, and forced 0 whenever rst=1.
REQ-030 Latched address/data are frozen from grant to ack; input changes mid-transaction are ignored.
REQ-031 Outside IDLE, new requests wait; no request is lost or served twice.
REQ-032 Addresses beyond RAM_WORDS are passed through unmodified; no wrap or error.

Reset
REQ-033 rst=1 at edge: state IDLE, round-robin bit to core-first, all acks/err 0, rdata regs 0.
REQ-034 rst asserted in ACCESS or MERGE_WR: transaction abandoned, no RAM write that cycle, no ack issued.
REQ-035 During rst, ram_addr, ram_wdata are 0.

Verification
REQ-036 Core lw 0x0001_05AC, RAM word 0x00626261 -> c_ack 2 cycles later, c_rdata 0x00626261, c_err 0.
REQ-037 Core lb signed addr 0x0001_05AE, word 0x00806261 -> c_rdata 0xFFFFFF80; lbu -> 0x00000080.
REQ-038 Core sh 0x1234 at 0x0001_05B2 over 0xAABBCCDD -> ram_we in MERGE_WR with 0x1234CCDD, c_ack 3 cycles after grant.
REQ-039 Core and loader request same cycle after reset -> core acked first, loader next; repeated simultaneous requests alternate.
REQ-040 Core sw at 0x0001_05A2 -> c_ack=c_err=1, ram_we never asserted; c_size=11 -> same.
REQ-041 rst pulsed during MERGE_WR -> no write, no ack, IDLE after reset, target word unchanged.

Source files
------------

// File: rtl/dram_arbiter.sv
// dram_arbiter: two-port (core, loader) round-robin arbiter in front of a
// single-ported word RAM. Core accesses may be byte/halfword/word with sign or
// zero extension on loads; sub-word stores use a read-modify-write cycle.
// Loader accesses are always whole words.
module dram_arbiter #(
  parameter int unsigned RAM_WORDS = 120072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [1:0]  c_size,
  input  logic        c_unsigned,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_ack,
  output logic        c_err,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic [31:0] l_rdata,
  output logic        l_ack,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_MERGE  = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]  state_q, state_d;
  logic        last_ld_q, last_ld_d;   // 1: loader was granted last (core wins ties next)
  logic        sel_ld_q, sel_ld_d;     // owner of the transaction in flight
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] merged_q, merged_d;
  logic        c_ack_q, c_ack_d;
  logic        c_err_q, c_err_d;
  logic [31:0] c_rdata_q, c_rdata_d;
  logic        l_ack_q, l_ack_d;
  logic [31:0] l_rdata_q, l_rdata_d;

  logic        c_elig, l_elig, c_bad;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext, merge_word;

  assign c_ack   = c_ack_q;
  assign c_err   = c_err_q;
  assign c_rdata = c_rdata_q;
  assign l_ack   = l_ack_q;
  assign l_rdata = l_rdata_q;

  // Lane extraction/extension for loads and lane insertion for sub-word stores
  always_comb begin
    rd_byte = ram_rdata[7:0];
    case (addr_q[1:0])
      2'd0: rd_byte = ram_rdata[7:0];
      2'd1: rd_byte = ram_rdata[15:8];
      2'd2: rd_byte = ram_rdata[23:16];
      default: rd_byte = ram_rdata[31:24];
    endcase
    rd_half = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (size_q)
      SZ_BYTE: ld_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: ld_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: ld_ext = ram_rdata;
    endcase
    merge_word = ram_rdata;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0: merge_word = {ram_rdata[31:8], wdata_q[7:0]};
        2'd1: merge_word = {ram_rdata[31:16], wdata_q[7:0], ram_rdata[7:0]};
        2'd2: merge_word = {ram_rdata[31:24], wdata_q[7:0], ram_rdata[15:0]};
        default: merge_word = {wdata_q[7:0], ram_rdata[23:0]};
      endcase
    end else if (size_q == SZ_HALF) begin
      merge_word = addr_q[1] ? {wdata_q[15:0], ram_rdata[15:0]}
                             : {ram_rdata[31:16], wdata_q[15:0]};
    end
  end

  // Arbitration, FSM next state and RAM port drive
  always_comb begin
    state_d   = state_q;
    last_ld_d = last_ld_q;
    sel_ld_d  = sel_ld_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    merged_d  = merged_q;
    c_ack_d   = 1'b0;
    c_err_d   = 1'b0;
    c_rdata_d = c_rdata_q;
    l_ack_d   = 1'b0;
    l_rdata_d = l_rdata_q;
    ram_we    = 1'b0;
    ram_addr  = {addr_q[31:2], 2'b00};
    ram_wdata = wdata_q;

    // A port whose ack is showing is still holding req; don't serve it twice.
    c_elig = c_req & ~c_ack_q;
    l_elig = l_req & ~l_ack_q;
    c_bad  = (c_size == 2'b11) | ((c_size == SZ_HALF) & c_addr[0]) |
             ((c_size == SZ_WORD) & (c_addr[1:0] != 2'b00));

    case (state_q)
      S_IDLE: begin
        if (c_elig && (!l_elig || last_ld_q)) begin
          sel_ld_d  = 1'b0;
          last_ld_d = 1'b0;
          we_d      = c_we;
          size_d    = c_size;
          uns_d     = c_unsigned;
          addr_d    = c_addr;
          wdata_d   = c_wdata;
          err_d     = c_bad;
          state_d   = S_ACCESS;
        end else if (l_elig) begin
          sel_ld_d  = 1'b1;
          last_ld_d = 1'b1;
          we_d      = l_we;
          size_d    = SZ_WORD;
          uns_d     = 1'b0;
          addr_d    = {l_addr[31:2], 2'b00};
          wdata_d   = l_wdata;
          err_d     = 1'b0;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        ram_we = we_q & ~err_q & (size_q == SZ_WORD);
        if (we_q && !err_q && size_q != SZ_WORD) begin
          merged_d = merge_word;
          state_d  = S_MERGE;
        end else begin
          state_d = S_IDLE;
          if (sel_ld_q) begin
            l_ack_d   = 1'b1;
            l_rdata_d = we_q ? 32'h0 : ram_rdata;
          end else begin
            c_ack_d   = 1'b1;
            c_err_d   = err_q;
            c_rdata_d = (err_q || we_q) ? 32'h0 : ld_ext;
          end
        end
      end
      S_MERGE: begin
        ram_we    = 1'b1;
        ram_wdata = merged_q;
        c_ack_d   = 1'b1;
        c_rdata_d = 32'h0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset kills any RAM write in the same cycle and parks the bus at zero.
    if (rst) begin
      ram_we    = 1'b0;
      ram_addr  = 32'h0;
      ram_wdata = 32'h0;
    end
  end

  // State registers with synchronous reset; a reset mid-transaction drops it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_ld_q <= 1'b1;
      sel_ld_q  <= 1'b0;
      we_q      <= 1'b0;
      size_q    <= SZ_WORD;
      uns_q     <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      err_q     <= 1'b0;
      merged_q  <= 32'h0;
      c_ack_q   <= 1'b0;
      c_err_q   <= 1'b0;
      c_rdata_q <= 32'h0;
      l_ack_q   <= 1'b0;
      l_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      last_ld_q <= last_ld_d;
      sel_ld_q  <= sel_ld_d;
      we_q      <= we_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      merged_q  <= merged_d;
      c_ack_q   <= c_ack_d;
      c_err_q   <= c_err_d;
      c_rdata_q <= c_rdata_d;
      l_ack_q   <= l_ack_d;
      l_rdata_q <= l_rdata_d;
    end
  end

endmodule
